// File: rtl/psx_pkg.sv
// Shared PSX protocol constants and the pad-responder FSM state encoding.
package psx_pkg;

  localparam logic [7:0] PSX_ADDR_PAD   = 8'h01;
  localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
  localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
  localparam logic [7:0] PSX_ID_TRAILER = 8'h5A;
  localparam logic [7:0] PSX_REPLY_IDLE = 8'hFF;

  typedef enum logic [2:0] {
    S_ADDR,
    S_CMD,
    S_ID,
    S_BTN_LO,
    S_BTN_HI,
    S_IGNORE
  } psx_state_t;

endpackage

// File: rtl/psx_sync_bus.sv
// Parameter-width two-flop synchronizer, cleared by the asynchronous packet reset.
module psx_sync_bus #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/psx_pad_responder.sv
// Digital-pad protocol engine on the PSX parallel bus: sequences the poll
// transaction, supplies reply bytes and ack requests, and reports motor bytes.
module psx_pad_responder
  import psx_pkg::*;
#(
  parameter logic [7:0] PAD_ADDR = PSX_ADDR_PAD,
  parameter logic [7:0] POLL_CMD = PSX_CMD_POLL,
  parameter logic [7:0] PAD_ID   = PSX_ID_DIGITAL
) (
  input  logic        clk,
  input  logic        PPB_packet_reset,
  input  logic [7:0]  PPB_command,
  input  logic        PPB_command_strobe,
  output logic [7:0]  PPB_reply,
  output logic        PPB_ack_strobe,
  input  logic [15:0] buttons,
  input  logic        pad_present,
  output logic [7:0]  motor_small,
  output logic [7:0]  motor_large,
  output logic        poll_done
);

  logic [16:0] w_sync;
  logic [15:0] w_buttons_s;
  logic        w_present_s;

  psx_sync_bus #(.WIDTH(17)) u_sync (
    .clk   (clk),
    .i_rst (PPB_packet_reset),
    .i_d   ({pad_present, buttons}),
    .o_q   (w_sync)
  );

  assign w_buttons_s = w_sync[15:0];
  assign w_present_s = w_sync[16];

  psx_state_t r_state;
  psx_state_t w_state_nxt;
  logic [15:0] r_snap;
  logic [7:0]  r_reply;
  logic [7:0]  w_reply_nxt;
  logic        r_ack;
  logic        w_ack_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic [7:0]  r_motor_small;
  logic [7:0]  r_motor_large;
  logic        w_snap_en;
  logic        w_small_en;
  logic        w_large_en;

  // Reply holds between strobes; ack and poll_done are single-cycle pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_reply_nxt = r_reply;
    w_ack_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_snap_en   = 1'b0;
    w_small_en  = 1'b0;
    w_large_en  = 1'b0;
    if (PPB_command_strobe) begin
      w_reply_nxt = PSX_REPLY_IDLE;
      w_state_nxt = S_IGNORE;
      case (r_state)
        S_ADDR: begin
          if (PPB_command == PAD_ADDR && w_present_s) begin
            w_ack_nxt   = 1'b1;
            w_reply_nxt = PAD_ID;
            w_state_nxt = S_CMD;
          end
        end
        S_CMD: begin
          if (PPB_command == POLL_CMD) begin
            w_ack_nxt   = 1'b1;
            w_reply_nxt = PSX_ID_TRAILER;
            w_snap_en   = 1'b1;
            w_state_nxt = S_ID;
          end
        end
        S_ID: begin
          w_ack_nxt   = 1'b1;
          w_reply_nxt = ~r_snap[7:0];
          w_state_nxt = S_BTN_LO;
        end
        S_BTN_LO: begin
          w_ack_nxt   = 1'b1;
          w_small_en  = 1'b1;
          w_reply_nxt = ~r_snap[15:8];
          w_state_nxt = S_BTN_HI;
        end
        S_BTN_HI: begin
          w_large_en  = 1'b1;
          w_done_nxt  = 1'b1;
        end
        default: begin
          w_state_nxt = S_IGNORE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge PPB_packet_reset) begin
    if (PPB_packet_reset) begin
      r_state       <= S_ADDR;
      r_snap        <= '0;
      r_reply       <= PSX_REPLY_IDLE;
      r_ack         <= 1'b0;
      r_done        <= 1'b0;
      r_motor_small <= '0;
      r_motor_large <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_reply <= w_reply_nxt;
      r_ack   <= w_ack_nxt;
      r_done  <= w_done_nxt;
      if (w_snap_en)  r_snap        <= w_buttons_s;
      if (w_small_en) r_motor_small <= PPB_command;
      if (w_large_en) r_motor_large <= PPB_command;
    end
  end

  assign PPB_reply      = r_reply;
  assign PPB_ack_strobe = r_ack;
  assign poll_done      = r_done;
  assign motor_small    = r_motor_small;
  assign motor_large    = r_motor_large;

endmodule

// File: tb/tb_psx_pad_responder.sv
// Bench for psx_pad_responder: directed packet table plus randomized packets
// checked against a positional model of the poll transaction.
module tb_psx_pad_responder;

  logic        clk = 1'b0;
  logic        PPB_packet_reset = 1'b1;
  logic [7:0]  PPB_command = 8'h00;
  logic        PPB_command_strobe = 1'b0;
  logic [7:0]  PPB_reply;
  logic        PPB_ack_strobe;
  logic [15:0] buttons = 16'h0000;
  logic        pad_present = 1'b1;
  logic [7:0]  motor_small;
  logic [7:0]  motor_large;
  logic        poll_done;

  psx_pad_responder dut (
    .clk                (clk),
    .PPB_packet_reset   (PPB_packet_reset),
    .PPB_command        (PPB_command),
    .PPB_command_strobe (PPB_command_strobe),
    .PPB_reply          (PPB_reply),
    .PPB_ack_strobe     (PPB_ack_strobe),
    .buttons            (buttons),
    .pad_present        (pad_present),
    .motor_small        (motor_small),
    .motor_large        (motor_large),
    .poll_done          (poll_done)
  );

  always #5 clk = ~clk;

  // b: host bytes; rep[k]: reply on the wire during byte k; ack[k]: ack after byte k.
  typedef struct packed {
    logic [2:0]      n;
    logic [0:5][7:0] b;
    logic [15:0]     btn;
    logic            pp;
    logic [1:0]      gap;
    logic            chg;
    logic [0:6][7:0] rep;
    logic [0:5]      ack;
    logic            done;
    logic [7:0]      ms;
    logic [7:0]      ml;
  } vec_t;

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a poll is valid only when byte 0 addresses a present pad and
  // byte 1 is the poll command; everything else on the wire is FF.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.rep  = {7{8'hFF}};
    r.ack  = '0;
    r.done = 1'b0;
    r.ms   = 8'h00;
    r.ml   = 8'h00;
    if (v.pp && v.b[0] == 8'h01) begin
      r.ack[0] = 1'b1;
      r.rep[1] = 8'h41;
      if (v.n >= 2 && v.b[1] == 8'h42) begin
        r.ack[1] = 1'b1;
        r.rep[2] = 8'h5A;
        r.ack[2] = 1'b1;
        r.rep[3] = ~v.btn[7:0];
        r.ack[3] = 1'b1;
        r.rep[4] = ~v.btn[15:8];
        if (v.n >= 4) r.ms = v.b[3];
        if (v.n >= 5) begin
          r.done = 1'b1;
          r.ml   = v.b[4];
        end
      end
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    PPB_packet_reset = 1'b1;
    PPB_command_strobe = 1'b0;
    @(negedge clk);
    chk("rst_reply", PPB_reply, 8'hFF);
    chk("rst_ack", PPB_ack_strobe, 1'b0);
    chk("rst_done", poll_done, 1'b0);
    chk("rst_msmall", motor_small, 8'h00);
    chk("rst_mlarge", motor_large, 8'h00);
    PPB_packet_reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input vec_t v, input string tag);
    logic exp_done;
    buttons = v.btn;
    pad_present = v.pp;
    do_reset();
    for (int k = 0; k < int'(v.n); k++) begin
      chk($sformatf("%s_reply%0d", tag, k), PPB_reply, v.rep[k]);
      PPB_command_strobe = 1'b1;
      PPB_command = v.b[k];
      @(negedge clk);
      exp_done = v.done && (k == 4);
      chk($sformatf("%s_ack%0d", tag, k), PPB_ack_strobe, v.ack[k]);
      chk($sformatf("%s_done%0d", tag, k), poll_done, exp_done);
      if (exp_done) begin
        chk($sformatf("%s_msmall", tag), motor_small, v.ms);
        chk($sformatf("%s_mlarge", tag), motor_large, v.ml);
      end
      if (v.chg && k == 2) buttons = 16'hFFFF;
      if (v.gap > 0) begin
        PPB_command_strobe = 1'b0;
        repeat (v.gap) begin
          @(negedge clk);
          chk($sformatf("%s_idle_ack%0d", tag, k), PPB_ack_strobe, 1'b0);
          chk($sformatf("%s_idle_done%0d", tag, k), poll_done, 1'b0);
        end
      end
    end
    PPB_command_strobe = 1'b0;
    chk($sformatf("%s_reply_end", tag), PPB_reply, v.rep[v.n]);
    chk($sformatf("%s_msmall_end", tag), motor_small, v.ms);
    chk($sformatf("%s_mlarge_end", tag), motor_large, v.ml);
    @(negedge clk);
    chk($sformatf("%s_tail_done", tag), poll_done, 1'b0);
    chk($sformatf("%s_tail_ack", tag), PPB_ack_strobe, 1'b0);
  endtask

  vec_t tbl[7];
  vec_t v;

  initial begin
    tbl[0] = '{3'd5, {8'h01, 8'h42, 8'h00, 8'h11, 8'h22, 8'h00}, 16'h0009, 1'b1, 2'd2, 1'b0,
               {8'hFF, 8'h41, 8'h5A, 8'hF6, 8'hFF, 8'hFF, 8'hFF}, 6'b111100, 1'b1, 8'h11, 8'h22};
    tbl[1] = '{3'd3, {8'h02, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00}, 16'h0009, 1'b1, 2'd1, 1'b0,
               {7{8'hFF}}, 6'b000000, 1'b0, 8'h00, 8'h00};
    tbl[2] = '{3'd3, {8'h01, 8'h43, 8'h00, 8'h00, 8'h00, 8'h00}, 16'h0009, 1'b1, 2'd1, 1'b0,
               {8'hFF, 8'h41, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 6'b100000, 1'b0, 8'h00, 8'h00};
    tbl[3] = '{3'd5, {8'h01, 8'h42, 8'h00, 8'h11, 8'h22, 8'h00}, 16'h0009, 1'b0, 2'd1, 1'b0,
               {7{8'hFF}}, 6'b000000, 1'b0, 8'h00, 8'h00};
    tbl[4] = '{3'd5, {8'h01, 8'h42, 8'h00, 8'hAB, 8'hCD, 8'h00}, 16'h1234, 1'b1, 2'd0, 1'b0,
               {8'hFF, 8'h41, 8'h5A, 8'hCB, 8'hED, 8'hFF, 8'hFF}, 6'b111100, 1'b1, 8'hAB, 8'hCD};
    tbl[5] = '{3'd5, {8'h01, 8'h42, 8'h00, 8'h33, 8'h44, 8'h00}, 16'h0000, 1'b1, 2'd1, 1'b1,
               {8'hFF, 8'h41, 8'h5A, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 6'b111100, 1'b1, 8'h33, 8'h44};
    tbl[6] = '{3'd6, {8'h01, 8'h42, 8'h00, 8'h01, 8'h02, 8'h55}, 16'h80FF, 1'b1, 2'd1, 1'b0,
               {8'hFF, 8'h41, 8'h5A, 8'h00, 8'h7F, 8'hFF, 8'hFF}, 6'b111100, 1'b1, 8'h01, 8'h02};

    for (int i = 0; i < 7; i++) run(tbl[i], $sformatf("row%0d", i));

    // Abort after byte 2, then a clean poll; no poll_done may leak out.
    v = tbl[0];
    v.n = 3'd3; v.done = 1'b0; v.ms = 8'h00; v.ml = 8'h00;
    run(v, "abort");
    #2 PPB_packet_reset = 1'b1;
    #1;
    chk("abort_async_reply", PPB_reply, 8'hFF);
    chk("abort_done", poll_done, 1'b0);
    @(negedge clk);
    PPB_packet_reset = 1'b0;
    run(tbl[0], "after_abort");

    // A pending ack is dropped by an asynchronous reset.
    pad_present = 1'b1;
    do_reset();
    PPB_command = 8'h01;
    PPB_command_strobe = 1'b1;
    @(posedge clk);
    #1;
    PPB_command_strobe = 1'b0;
    chk("pend_ack_set", PPB_ack_strobe, 1'b1);
    PPB_packet_reset = 1'b1;
    #1;
    chk("pend_ack_drop", PPB_ack_strobe, 1'b0);
    chk("pend_reply", PPB_reply, 8'hFF);
    @(negedge clk);
    PPB_packet_reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      v = '0;
      v.n = 3'(int'($urandom_range(1, 6)));
      for (int j = 0; j < 6; j++) v.b[j] = 8'($urandom);
      if ($urandom_range(0, 3) != 0) v.b[0] = 8'h01;
      if ($urandom_range(0, 3) != 0) v.b[1] = 8'h42;
      v.btn = 16'($urandom);
      v.pp  = ($urandom_range(0, 4) != 0);
      v.gap = 2'(int'($urandom_range(0, 2)));
      v = model(v);
      run(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
